// File: rtl/instruction_encoder_pkg.sv
// rtl/instruction_encoder_pkg.sv - shared widths and opcode class type for the instruction encoder loader
package instruction_encoder_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    typedef enum logic [3:0] {
        OPCODE_LUI     = 4'd0,
        OPCODE_AUIPC   = 4'd1,
        OPCODE_JAL     = 4'd2,
        OPCODE_JALR    = 4'd3,
        OPCODE_BRANCH  = 4'd4,
        OPCODE_LOAD    = 4'd5,
        OPCODE_STORE   = 4'd6,
        OPCODE_OP_IMM  = 4'd7,
        OPCODE_OP      = 4'd8,
        OPCODE_UNKNOWN = 4'd9
    } opcode_t;

endpackage

// File: rtl/instruction_encoder_loader.sv
// rtl/instruction_encoder_loader.sv - packs field-level requests into RV32I words and streams them to imem
// Optional immediate range flagging: define IMM_RANGE_CHECK_EN.
module instruction_encoder_loader
    import instruction_encoder_pkg::*;
#(
    parameter int COUNT_W   = 16,
    parameter int ADDR_STEP = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               start_i,
    input  logic [XLEN-1:0]    base_addr_i,
    output logic               busy_o,
    output logic               done_o,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic               in_last_i,
    input  opcode_t            in_opcode_i,
    input  logic [4:0]         in_rd_i,
    input  logic [4:0]         in_rs1_i,
    input  logic [4:0]         in_rs2_i,
    input  logic [2:0]         in_funct3_i,
    input  logic [6:0]         in_funct7_i,
    input  logic [XLEN-1:0]    in_imm_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [ILEN-1:0]    out_instr_o,
    output logic [XLEN-1:0]    out_addr_o,
    output logic               out_err_o,
    output logic [COUNT_W-1:0] instr_count_o
);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [XLEN-1:0]    addr_q, addr_d;
    logic               out_valid_q, out_valid_d;
    logic [ILEN-1:0]    out_instr_q, out_instr_d;
    logic [XLEN-1:0]    out_addr_q, out_addr_d;
    logic               out_err_q, out_err_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               done_q, done_d;

    logic [ILEN-1:0]    enc_word;
    logic               enc_err;
    logic [11:0]        i_imm;
    logic               accept, out_hs;

    // Shift-immediates carry funct7 in the upper immediate bits.
    assign i_imm = ((in_opcode_i == OPCODE_OP_IMM) && (in_funct3_i[1:0] == 2'b01))
                 ? {in_funct7_i, in_imm_i[4:0]} : in_imm_i[11:0];

`ifdef IMM_RANGE_CHECK_EN
    logic fits12, fits13, fits21, u_ok;
    assign fits12 = (&in_imm_i[31:11]) | ~(|in_imm_i[31:11]);
    assign fits13 = ((&in_imm_i[31:12]) | ~(|in_imm_i[31:12])) & ~in_imm_i[0];
    assign fits21 = ((&in_imm_i[31:20]) | ~(|in_imm_i[31:20])) & ~in_imm_i[0];
    assign u_ok   = ~(|in_imm_i[11:0]);
`endif

    always_comb begin
        enc_word = '0;
        enc_err  = 1'b0;
        case (in_opcode_i)
            OPCODE_LUI, OPCODE_AUIPC: begin
                enc_word = {in_imm_i[31:12], in_rd_i,
                            (in_opcode_i == OPCODE_LUI) ? 7'b0110111 : 7'b0010111};
`ifdef IMM_RANGE_CHECK_EN
                enc_err  = ~u_ok;
`endif
            end
            OPCODE_JAL: begin
                enc_word = {in_imm_i[20], in_imm_i[10:1], in_imm_i[11], in_imm_i[19:12],
                            in_rd_i, 7'b1101111};
`ifdef IMM_RANGE_CHECK_EN
                enc_err  = ~fits21;
`endif
            end
            OPCODE_JALR, OPCODE_LOAD, OPCODE_OP_IMM: begin
                enc_word = {i_imm, in_rs1_i, in_funct3_i, in_rd_i,
                            (in_opcode_i == OPCODE_JALR) ? 7'b1100111 :
                            (in_opcode_i == OPCODE_LOAD) ? 7'b0000011 : 7'b0010011};
`ifdef IMM_RANGE_CHECK_EN
                enc_err  = ~fits12;
`endif
            end
            OPCODE_OP: begin
                enc_word = {in_funct7_i, in_rs2_i, in_rs1_i, in_funct3_i, in_rd_i, 7'b0110011};
            end
            OPCODE_STORE: begin
                enc_word = {in_imm_i[11:5], in_rs2_i, in_rs1_i, in_funct3_i, in_imm_i[4:0],
                            7'b0100011};
`ifdef IMM_RANGE_CHECK_EN
                enc_err  = ~fits12;
`endif
            end
            OPCODE_BRANCH: begin
                enc_word = {in_imm_i[12], in_imm_i[10:5], in_rs2_i, in_rs1_i, in_funct3_i,
                            in_imm_i[4:1], in_imm_i[11], 7'b1100011};
`ifdef IMM_RANGE_CHECK_EN
                enc_err  = ~fits13;
`endif
            end
            default: begin
                enc_word = '0;
                enc_err  = 1'b1;
            end
        endcase
    end

    assign in_ready_o = (state_q == S_STREAM) && (!out_valid_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign out_hs     = out_valid_q && out_ready_i;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        out_err_d   = out_err_q;
        count_d     = count_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_STREAM;
                    addr_d  = base_addr_i;
                    count_d = '0;
                end
            end
            S_STREAM: begin
                if (accept && in_last_i) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (out_hs) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (out_hs) out_valid_d = 1'b0;
        // An accept in the same cycle as an output handshake overwrites the slot with no bubble.
        if (accept) begin
            out_valid_d = 1'b1;
            out_instr_d = enc_word;
            out_addr_d  = addr_q;
            out_err_d   = enc_err;
            addr_d      = addr_q + XLEN'(ADDR_STEP);
            count_d     = (&count_q) ? count_q : count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= '0;
            out_err_q   <= 1'b0;
            count_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            out_err_q   <= out_err_d;
            count_q     <= count_d;
            done_q      <= done_d;
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;
    assign out_valid_o   = out_valid_q;
    assign out_instr_o   = out_instr_q;
    assign out_addr_o    = out_addr_q;
    assign out_err_o     = out_err_q;
    assign instr_count_o = count_q;

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// tb/tb_instruction_encoder_loader.sv - randomized bench for instruction_encoder_loader against a field-level model
module tb_instruction_encoder_loader;
    import instruction_encoder_pkg::*;

    localparam int CW     = 4;
    localparam int CNTMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n_i, start_i, in_valid_i, in_last_i, out_ready_i;
    logic [31:0]   base_addr_i, in_imm_i;
    opcode_t       in_opcode_i;
    logic [4:0]    in_rd_i, in_rs1_i, in_rs2_i;
    logic [2:0]    in_funct3_i;
    logic [6:0]    in_funct7_i;
    logic          busy_o, done_o, in_ready_o, out_valid_o, out_err_o;
    logic [31:0]   out_instr_o, out_addr_o;
    logic [CW-1:0] instr_count_o;

    instruction_encoder_loader #(.COUNT_W(CW), .ADDR_STEP(4)) dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .start_i(start_i), .base_addr_i(base_addr_i),
        .busy_o(busy_o), .done_o(done_o), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_last_i(in_last_i), .in_opcode_i(in_opcode_i), .in_rd_i(in_rd_i),
        .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i), .in_funct3_i(in_funct3_i),
        .in_funct7_i(in_funct7_i), .in_imm_i(in_imm_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_instr_o(out_instr_o), .out_addr_o(out_addr_o),
        .out_err_o(out_err_o), .instr_count_o(instr_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        opcode_t     op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        bit          has_gold;
        logic [31:0] gold;
    } req_t;

    req_t        src[$];
    logic [31:0] q_instr[$];
    logic [31:0] q_addr[$];
    logic        q_err[$];
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fld(logic [31:0] v, int hi, int lo);
        return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
    endfunction

    function automatic logic [31:0] opc_of(opcode_t op);
        case (op)
            OPCODE_LUI:    return 32'h37;
            OPCODE_AUIPC:  return 32'h17;
            OPCODE_JAL:    return 32'h6F;
            OPCODE_JALR:   return 32'h67;
            OPCODE_BRANCH: return 32'h63;
            OPCODE_LOAD:   return 32'h03;
            OPCODE_STORE:  return 32'h23;
            OPCODE_OP_IMM: return 32'h13;
            OPCODE_OP:     return 32'h33;
            default:       return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_word(req_t r);
        logic [31:0] rd, rs1, rs2, f3, f7, opc, immf;
        rd = 32'(r.rd) << 7; rs1 = 32'(r.rs1) << 15; rs2 = 32'(r.rs2) << 20;
        f3 = 32'(r.f3) << 12; f7 = 32'(r.f7); opc = opc_of(r.op);
        case (r.op)
            OPCODE_LUI, OPCODE_AUIPC:
                return (fld(r.imm, 31, 12) << 12) | rd | opc;
            OPCODE_JAL:
                return (fld(r.imm, 20, 20) << 31) | (fld(r.imm, 10, 1) << 21) |
                       (fld(r.imm, 11, 11) << 20) | (fld(r.imm, 19, 12) << 12) | rd | opc;
            OPCODE_JALR, OPCODE_LOAD, OPCODE_OP_IMM: begin
                immf = fld(r.imm, 11, 0);
                if (r.op == OPCODE_OP_IMM && (r.f3 == 3'd1 || r.f3 == 3'd5))
                    immf = (f7 << 5) | fld(r.imm, 4, 0);
                return (immf << 20) | rs1 | f3 | rd | opc;
            end
            OPCODE_OP:
                return (f7 << 25) | rs2 | rs1 | f3 | rd | opc;
            OPCODE_STORE:
                return (fld(r.imm, 11, 5) << 25) | rs2 | rs1 | f3 | (fld(r.imm, 4, 0) << 7) | opc;
            OPCODE_BRANCH:
                return (fld(r.imm, 12, 12) << 31) | (fld(r.imm, 10, 5) << 25) | rs2 | rs1 | f3 |
                       (fld(r.imm, 4, 1) << 8) | (fld(r.imm, 11, 11) << 7) | opc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic ref_err(req_t r);
        int si;
        bit odd;
        si  = $signed(r.imm);
        odd = (r.imm & 32'd1) != 0;
        if (r.op == OPCODE_UNKNOWN) return 1'b1;
`ifdef IMM_RANGE_CHECK_EN
        case (r.op)
            OPCODE_LUI, OPCODE_AUIPC: return (r.imm % 32'd4096) != 0;
            OPCODE_JAL:    return !(si >= -(1 << 20) && si < (1 << 20) && !odd);
            OPCODE_BRANCH: return !(si >= -4096 && si < 4096 && !odd);
            OPCODE_OP:     return 1'b0;
            default:       return !(si >= -2048 && si < 2048);
        endcase
`else
        return (si != si) || odd != odd;
`endif
    endfunction

    function automatic req_t mk(opcode_t op, int rd, int rs1, int rs2, int f3, int f7,
                                logic [31:0] imm, bit hg, logic [31:0] gold);
        req_t r;
        r.op = op; r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2);
        r.f3 = 3'(f3); r.f7 = 7'(f7); r.imm = imm; r.has_gold = hg; r.gold = gold;
        return r;
    endfunction

    function automatic req_t rnd_req();
        req_t r;
        int   t;
        r = mk(opcode_t'(4'($urandom_range(8))), int'($urandom_range(31)), int'($urandom_range(31)),
               int'($urandom_range(31)), int'($urandom_range(7)), int'($urandom_range(127)),
               32'h0, 1'b0, 32'h0);
        if ($urandom_range(15) == 0) r.op = OPCODE_UNKNOWN;
        case ($urandom_range(3))
            0: r.imm = $urandom;
            1: begin t = int'($urandom_range(4095)) - 2048; r.imm = 32'(t); end
            2: begin t = int'($urandom_range(8191)) - 4096; r.imm = 32'(t) & ~32'd1; end
            default: r.imm = $urandom & 32'hFFFFF000;
        endcase
        return r;
    endfunction

    task automatic run_burst(input logic [31:0] base, input int vld_pct, input int rdy_pct,
                             input int stall_from);
        int          st;
        int          cyc;
        int          mcount;
        logic [31:0] maddr;
        bit          exp_rdy;
        @(negedge clk);
        start_i = 1'b1; base_addr_i = base;
        #1;
        check("idle_busy", busy_o, 0);
        check("idle_in_ready", in_ready_o, 0);
        @(negedge clk);
        st = 1; maddr = base; mcount = 0; cyc = 0;
        while (st != 0 && cyc < 2000) begin
            if (cyc >= stall_from && cyc < stall_from + 3) out_ready_i = 1'b0;
            else out_ready_i = ($urandom_range(99) < rdy_pct);
            start_i = (cyc > 0) && ($urandom_range(3) == 0);
            base_addr_i = $urandom;
            if (src.size() > 0 && $urandom_range(99) < vld_pct) begin
                in_valid_i = 1'b1; in_last_i = (src.size() == 1);
                in_opcode_i = src[0].op; in_rd_i = src[0].rd; in_rs1_i = src[0].rs1;
                in_rs2_i = src[0].rs2; in_funct3_i = src[0].f3; in_funct7_i = src[0].f7;
                in_imm_i = src[0].imm;
            end else begin
                in_valid_i = 1'b0; in_last_i = 1'($urandom_range(1)); in_imm_i = $urandom;
            end
            #1;
            exp_rdy = (st == 1) && (q_instr.size() == 0 || out_ready_i);
            check("busy", busy_o, 1);
            check("done_early", done_o, 0);
            check("out_valid", out_valid_o, q_instr.size() != 0);
            check("in_ready", in_ready_o, exp_rdy);
            check("count", instr_count_o, mcount);
            if (q_instr.size() != 0) begin
                check("out_instr", out_instr_o, q_instr[0]);
                check("out_addr", out_addr_o, q_addr[0]);
                check("out_err", out_err_o, q_err[0]);
            end
            if (out_ready_i && q_instr.size() != 0) begin
                void'(q_instr.pop_front()); void'(q_addr.pop_front()); void'(q_err.pop_front());
                if (st == 2) st = 0;
            end
            if (in_valid_i && exp_rdy) begin
                q_instr.push_back(src[0].has_gold ? src[0].gold : ref_word(src[0]));
                q_addr.push_back(maddr);
                q_err.push_back(ref_err(src[0]));
                maddr = maddr + 32'd4;
                if (mcount < CNTMAX) mcount++;
                if (src.size() == 1) st = 2;
                void'(src.pop_front());
            end
            cyc++;
            @(negedge clk);
        end
        if (st != 0) begin
            check("burst_timeout", 1, 0);
            src.delete(); q_instr.delete(); q_addr.delete(); q_err.delete();
        end
        start_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        #1;
        check("done_pulse", done_o, 1);
        check("busy_end", busy_o, 0);
        check("out_valid_end", out_valid_o, 0);
        check("count_end", instr_count_o, mcount);
        @(negedge clk);
        #1;
        check("done_once", done_o, 0);
    endtask

    initial begin
        reset_n_i = 1'b0; start_i = 1'b0; base_addr_i = 32'h0; in_valid_i = 1'b0;
        in_last_i = 1'b0; out_ready_i = 1'b1; in_opcode_i = OPCODE_OP; in_rd_i = 5'd0;
        in_rs1_i = 5'd0; in_rs2_i = 5'd0; in_funct3_i = 3'd0; in_funct7_i = 7'd0; in_imm_i = 32'h0;
        repeat (2) @(negedge clk);
        reset_n_i = 1'b1;
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_in_ready", in_ready_o, 0);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_out_err", out_err_o, 0);
        check("rst_out_instr", out_instr_o, 0);
        check("rst_out_addr", out_addr_o, 0);
        check("rst_count", instr_count_o, 0);

        src.push_back(mk(OPCODE_OP_IMM, 1, 0, 0, 0, 0, 32'd5, 1, 32'h00500093));
        run_burst(32'h100, 100, 100, -10);

        src.push_back(mk(OPCODE_OP, 3, 1, 2, 0, 0, 32'h0, 1, 32'h002081B3));
        src.push_back(mk(OPCODE_STORE, 0, 1, 2, 2, 0, 32'd8, 1, 32'h0020A423));
        src.push_back(mk(OPCODE_BRANCH, 0, 1, 2, 0, 0, 32'hFFFFFFFC, 1, 32'hFE208EE3));
        src.push_back(mk(OPCODE_JAL, 1, 0, 0, 0, 0, 32'd8, 1, 32'h008000EF));
        src.push_back(mk(OPCODE_LUI, 5, 0, 0, 0, 0, 32'h12345000, 1, 32'h123452B7));
        run_burst(32'h0, 100, 100, -10);

        for (int i = 0; i < 8; i++) src.push_back(rnd_req());
        run_burst(32'h2000, 100, 100, 2);

        src.push_back(mk(OPCODE_OP_IMM, 1, 0, 0, 0, 0, 32'd4096, 1, 32'h00000093));
        src.push_back(mk(OPCODE_UNKNOWN, 7, 3, 4, 5, 6, 32'h1234, 1, 32'h00000000));
        run_burst(32'h300, 100, 100, -10);

        for (int i = 0; i < 2; i++) src.push_back(rnd_req());
        run_burst(32'hFFFFFFFC, 100, 100, -10);

        for (int i = 0; i < 20; i++) src.push_back(rnd_req());
        run_burst(32'h1000, 80, 80, -10);

        for (int b = 0; b < 6; b++) begin
            int n;
            n = int'($urandom_range(10)) + 1;
            for (int i = 0; i < n; i++) src.push_back(rnd_req());
            run_burst($urandom & 32'hFFFFFFFC, int'($urandom_range(60)) + 40,
                      int'($urandom_range(60)) + 40, int'($urandom_range(6)));
        end

        @(negedge clk);
        start_i = 1'b1; base_addr_i = 32'h40;
        @(negedge clk);
        start_i = 1'b0; out_ready_i = 1'b0; in_valid_i = 1'b1; in_last_i = 1'b1;
        in_opcode_i = OPCODE_OP_IMM; in_rd_i = 5'd1; in_rs1_i = 5'd0; in_funct3_i = 3'd0;
        in_imm_i = 32'd5;
        @(negedge clk);
        in_valid_i = 1'b0;
        #1;
        check("drain_out_valid", out_valid_o, 1);
        check("drain_busy", busy_o, 1);
        check("drain_in_ready", in_ready_o, 0);
        reset_n_i = 1'b0;
        @(negedge clk);
        #1;
        check("rst_drain_out_valid", out_valid_o, 0);
        check("rst_drain_busy", busy_o, 0);
        check("rst_drain_done", done_o, 0);
        check("rst_drain_instr", out_instr_o, 0);
        check("rst_drain_addr", out_addr_o, 0);
        check("rst_drain_count", instr_count_o, 0);
        reset_n_i = 1'b1; out_ready_i = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_done", done_o, 0);
        check("post_rst_busy", busy_o, 0);

        for (int i = 0; i < 3; i++) src.push_back(rnd_req());
        run_burst(32'h500, 100, 100, -10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
